// File: rtl/acc_alu_if.sv
// Handshake and data bundle between the ALU sequencer, its controller and the accumulator.
interface acc_alu_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic             load_acc;
  logic             busy;
  logic             done;
  logic             carry;
  logic             zero;

  modport master (
    output start, opcode, operand, acc_q,
    input  acc_d, load_acc, busy, done, carry, zero
  );

  modport slave (
    input  start, opcode, operand, acc_q,
    output acc_d, load_acc, busy, done, carry, zero
  );
endinterface

// File: rtl/acc_alu_seq_n8.sv
// Multi-cycle ALU sequencer feeding the accumulator (shift-add MUL, bit-serial SHL).
// Optional feature: define ACC_ALU_SAT_EN to make ADD/SUB saturate instead of wrapping.
module acc_alu_seq_n8 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic      clk,
  input  logic      reset,
  acc_alu_if.slave  bus
);

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_SHL  = 3'd7;

  typedef enum logic [2:0] {IDLE, EXEC, MULT, SHIFT, WRITE} state_t;

  state_t               state_q, state_nxt;
  logic [2:0]           op_q, op_nxt;
  logic [WIDTH-1:0]     a_q, a_nxt;
  logic [WIDTH-1:0]     b_q, b_nxt;
  logic [2*WIDTH-1:0]   prod_q, prod_nxt;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic                 sc_q, sc_nxt;
  logic [WIDTH-1:0]     res_nxt;
  logic                 cy_nxt;
  logic [WIDTH:0]       sum_c, diff_c, mac_c;
  logic [2*WIDTH-1:0]   prod_step_c;

  // State, operand and result registers; handshake outputs follow the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      prod_q       <= '0;
      cnt_q        <= '0;
      sc_q         <= 1'b0;
      bus.acc_d    <= '0;
      bus.carry    <= 1'b0;
      bus.zero     <= 1'b0;
      bus.load_acc <= 1'b0;
      bus.done     <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      op_q         <= op_nxt;
      a_q          <= a_nxt;
      b_q          <= b_nxt;
      prod_q       <= prod_nxt;
      cnt_q        <= cnt_nxt;
      sc_q         <= sc_nxt;
      bus.load_acc <= (state_nxt == WRITE);
      bus.done     <= (state_nxt == WRITE);
      bus.busy     <= (state_nxt != IDLE);
      if (state_nxt == WRITE) begin
        bus.acc_d <= res_nxt;
        bus.carry <= cy_nxt;
        bus.zero  <= (res_nxt == '0);
      end
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    state_nxt = state_q;
    op_nxt    = op_q;
    a_nxt     = a_q;
    b_nxt     = b_q;
    prod_nxt  = prod_q;
    cnt_nxt   = cnt_q;
    sc_nxt    = sc_q;
    res_nxt   = '0;
    cy_nxt    = 1'b0;

    sum_c       = {1'b0, a_q} + {1'b0, b_q};
    diff_c      = {1'b0, a_q} - {1'b0, b_q};
    // One shift-add step: low half starts as B and is consumed LSB first.
    mac_c       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
    prod_step_c = {mac_c, prod_q[WIDTH-1:1]};

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_nxt   = bus.opcode;
          a_nxt    = bus.acc_q;
          b_nxt    = bus.operand;
          prod_nxt = {WIDTH'(0), bus.operand};
          sc_nxt   = 1'b0;
          if (bus.opcode == OP_MUL) begin
            cnt_nxt   = CNT_W'(WIDTH);
            state_nxt = MULT;
          end else if (bus.opcode == OP_SHL) begin
            cnt_nxt   = CNT_W'(bus.operand[2:0]);
            state_nxt = SHIFT;
          end else begin
            state_nxt = EXEC;
          end
        end
      end

      EXEC: begin
        state_nxt = WRITE;
        case (op_q)
          // PASS loads the operand into the accumulator.
          OP_PASS: res_nxt = b_q;
          OP_ADD: begin
            cy_nxt  = sum_c[WIDTH];
`ifdef ACC_ALU_SAT_EN
            res_nxt = sum_c[WIDTH] ? '1 : sum_c[WIDTH-1:0];
`else
            res_nxt = sum_c[WIDTH-1:0];
`endif
          end
          OP_SUB: begin
            cy_nxt  = diff_c[WIDTH];
`ifdef ACC_ALU_SAT_EN
            res_nxt = diff_c[WIDTH] ? '0 : diff_c[WIDTH-1:0];
`else
            res_nxt = diff_c[WIDTH-1:0];
`endif
          end
          OP_AND:  res_nxt = a_q & b_q;
          OP_OR:   res_nxt = a_q | b_q;
          OP_XOR:  res_nxt = a_q ^ b_q;
          default: res_nxt = a_q;
        endcase
      end

      MULT: begin
        prod_nxt = prod_step_c;
        cnt_nxt  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_nxt = WRITE;
          res_nxt   = prod_step_c[WIDTH-1:0];
          cy_nxt    = |prod_step_c[2*WIDTH-1:WIDTH];
        end
      end

      SHIFT: begin
        if (cnt_q != '0) begin
          a_nxt   = {a_q[WIDTH-2:0], 1'b0};
          sc_nxt  = a_q[WIDTH-1];
          cnt_nxt = cnt_q - CNT_W'(1);
        end else begin
          state_nxt = WRITE;
          res_nxt   = a_q;
          cy_nxt    = sc_q;
        end
      end

      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_acc_alu_seq_n8.sv
// Self-checking bench for acc_alu_seq_n8: directed spec vectors plus randomized ops vs. a reference model.
module tb_acc_alu_seq_n8;

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_SHL  = 3'd7;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;

  acc_alu_if #(.WIDTH(8)) bus ();

  acc_alu_seq_n8 #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model computed from the arithmetic rules with plain integers.
  task automatic model(input logic [2:0] op, input int a, input int b,
                       output logic [7:0] res, output logic cy);
    int r;
    int k;
    r  = 0;
    cy = 1'b0;
    case (op)
      3'd0: r = b;
      3'd1: begin
        r  = a + b;
        cy = (r > 255);
`ifdef ACC_ALU_SAT_EN
        if (cy) r = 255;
`endif
      end
      3'd2: begin
        cy = (a < b);
        r  = a - b;
`ifdef ACC_ALU_SAT_EN
        if (cy) r = 0;
`endif
      end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: begin
        r  = a * b;
        cy = (r > 255);
      end
      default: begin
        k  = b % 8;
        r  = a << k;
        cy = (k == 0) ? 1'b0 : (((a >> (8 - k)) & 1) == 1);
      end
    endcase
    res = 8'(r & 255);
  endtask

  function automatic int latency(input logic [2:0] op, input int b);
    if (op == OP_MUL) return 9;
    if (op == OP_SHL) return 2 + (b % 8);
    return 2;
  endfunction

  // Issue one operation, wait for load_acc (bounded) and check timing and results.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input string tag);
    logic [7:0] er;
    logic       ec;
    int         lat;
    int         n;
    bit         seen;
    model(op, int'(a), int'(b), er, ec);
    lat = latency(op, int'(b));
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = op; bus.operand = b; bus.acc_q = a;
    @(negedge clk);
    bus.start = 1'b0; bus.opcode = 3'($urandom); bus.operand = 8'($urandom); bus.acc_q = 8'($urandom);
    n = 1; seen = 0;
    while (!seen && n <= 20) begin
      if (bus.load_acc) seen = 1;
      else begin
        nvec++;
        if (bus.busy !== 1'b1) begin
          nerr++; $display("FAIL %s busy cycle %0d: got %b want 1", tag, n, bus.busy);
        end
        @(negedge clk); n++;
      end
    end
    nvec++;
    if (!seen || n != lat) begin
      nerr++; $display("FAIL %s latency: got %0d (seen=%0b) want %0d", tag, n, seen, lat);
    end
    if (seen) begin
      nvec += 4;
      if (bus.acc_d !== er) begin nerr++; $display("FAIL %s acc_d: got %02h want %02h", tag, bus.acc_d, er); end
      if (bus.carry !== ec) begin nerr++; $display("FAIL %s carry: got %b want %b", tag, bus.carry, ec); end
      if (bus.zero !== (er == 8'h00)) begin nerr++; $display("FAIL %s zero: got %b want %b", tag, bus.zero, er == 8'h00); end
      if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
        nerr++; $display("FAIL %s done/busy in write: got %b/%b want 1/1", tag, bus.done, bus.busy);
      end
      @(negedge clk);
      nvec += 2;
      if (bus.load_acc !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        nerr++; $display("FAIL %s after write load/done/busy: got %b%b%b want 000", tag, bus.load_acc, bus.done, bus.busy);
      end
      if (bus.acc_d !== er || bus.carry !== ec) begin
        nerr++; $display("FAIL %s hold acc_d/carry: got %02h/%b want %02h/%b", tag, bus.acc_d, bus.carry, er, ec);
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.opcode = '0; bus.operand = '0; bus.acc_q = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if ({bus.busy, bus.load_acc, bus.done, bus.carry, bus.zero} !== 5'b0 || bus.acc_d !== 8'h00) begin
      nerr++; $display("FAIL reset outputs: got busy=%b load=%b done=%b c=%b z=%b acc_d=%02h want all 0",
                       bus.busy, bus.load_acc, bus.done, bus.carry, bus.zero, bus.acc_d);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(OP_ADD, 8'hF0, 8'h20, "add_ovf");
    run_op(OP_SUB, 8'h05, 8'h05, "sub_zero");
    run_op(OP_SUB, 8'h03, 8'h05, "sub_borrow");
    run_op(OP_MUL, 8'h0D, 8'h0B, "mul_0d_0b");
    run_op(OP_MUL, 8'h20, 8'h10, "mul_ovf");
    run_op(OP_SHL, 8'h81, 8'h03, "shl_k3");
    run_op(OP_SHL, 8'h81, 8'h01, "shl_k1");
    run_op(OP_SHL, 8'h81, 8'h00, "shl_k0");
    run_op(OP_SHL, 8'h81, 8'h07, "shl_k7");
    run_op(OP_PASS, 8'h12, 8'hA5, "pass");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_op(3'($urandom), 8'($urandom), 8'($urandom), "random");
  endtask

  task automatic test_start_while_busy();
    int pulses;
    int n;
    pulses = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = OP_MUL; bus.operand = 8'h0B; bus.acc_q = 8'h0D;
    n = 0;
    while (pulses == 0 && n < 20) begin
      @(negedge clk); n++;
      if (bus.load_acc) begin
        pulses++;
        bus.start = 1'b0;
      end else begin
        bus.opcode = 3'($urandom); bus.operand = 8'($urandom); bus.acc_q = 8'($urandom);
      end
    end
    nvec += 2;
    if (n != 9) begin nerr++; $display("FAIL busy_start latency: got %0d want 9", n); end
    if (bus.acc_d !== 8'h8F) begin nerr++; $display("FAIL busy_start acc_d: got %02h want 8f", bus.acc_d); end
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.load_acc) pulses++;
      nvec++;
      if (bus.busy !== 1'b0) begin nerr++; $display("FAIL busy_start idle %0d: busy got %b want 0", i, bus.busy); end
    end
    nvec++;
    if (pulses != 1) begin nerr++; $display("FAIL busy_start pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    pulses = 0;
    run_op(OP_ADD, 8'h03, 8'h04, "pre_reset_add");
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = OP_MUL; bus.operand = 8'h0B; bus.acc_q = 8'h0D;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    nvec++;
    if (bus.busy !== 1'b0 || bus.acc_d !== 8'h00 || bus.load_acc !== 1'b0) begin
      nerr++; $display("FAIL reset_mid: got busy=%b acc_d=%02h load=%b want 0/00/0", bus.busy, bus.acc_d, bus.load_acc);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.load_acc) pulses++;
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.load_acc) pulses++;
    end
    nvec++;
    if (pulses != 0) begin nerr++; $display("FAIL reset_mid pulses: got %0d want 0", pulses); end
    run_op(OP_ADD, 8'h01, 8'h01, "post_reset_add");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
